// File: rtl/fifo_rd_stream.sv
// Read-side controller of the async FIFO: synchronizes the write Gray pointer,
// owns the read pointer, derives empty/fill, and pops words into a registered valid/ready stage.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FIFO_DEP   = 8
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rcount,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  if (FIFO_DEP != (1 << ADDR_WIDTH)) begin : g_dep_chk
    $error("FIFO_DEP must equal 2**ADDR_WIDTH");
  end

  logic [ADDR_WIDTH:0]   r_wq1, r_wq2;
  logic [ADDR_WIDTH:0]   r_rptr_bin, r_rptr_gray;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;

  logic [ADDR_WIDTH:0]   w_wq2_bin;
  logic [ADDR_WIDTH:0]   w_next_bin;
  logic [ADDR_WIDTH:0]   w_next_gray;
  logic                  w_empty;
  logic                  w_pop;

  // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wq2_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      w_wq2_bin[i] = ^(r_wq2 >> i);
    end
  end

  assign w_empty     = (r_rptr_gray == r_wq2);
  assign w_pop       = !w_empty && (!r_m_valid || m_ready);
  assign w_next_bin  = r_rptr_bin + {{ADDR_WIDTH{1'b0}}, w_pop};
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_wq1       <= '0;
      r_wq2       <= '0;
      r_rptr_bin  <= '0;
      r_rptr_gray <= '0;
    end else begin
      r_wq1       <= wptr_gray;
      r_wq2       <= r_wq1;
      r_rptr_bin  <= w_next_bin;
      r_rptr_gray <= w_next_gray;
    end
  end

  // Output stage: a pop refills it (even while the current word transfers).
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else if (w_pop) begin
      r_m_data  <= r_data;
      r_m_valid <= 1'b1;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign r_addr    = r_rptr_bin[ADDR_WIDTH-1:0];
  assign rptr_gray = r_rptr_gray;
  assign rempty    = w_empty;
  assign rcount    = w_wq2_bin - r_rptr_bin;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side controller of the asynchronous FIFO, running in the read clock domain. It synchronizes the write-domain Gray pointer, keeps the read pointer, and generates `rempty` and a fill estimate. It drives the read address into the FIFO memory and presents popped words on a registered valid/ready output stream. It is the counterpart of the write-side memory controller and shares its memory array and pointer encoding.

## Interface
- `DATA_WIDTH`, 8, width of each FIFO word.
- `ADDR_WIDTH`, 3, memory address width. Pointers are `ADDR_WIDTH+1` bits.
- `FIFO_DEP`, 8, memory depth. Must equal `2**ADDR_WIDTH`.

- `R_CLK`  in  1  read-domain clock.
- `R_RST`  in  1  asynchronous, active-low reset.
- `wptr_gray`  in  ADDR_WIDTH+1  write pointer, Gray-coded, from the write domain (unsynchronized).
- `r_data`  in  DATA_WIDTH  memory read data. The memory read path is combinational on `r_addr`.
- `r_addr`  out  ADDR_WIDTH  memory read address, `rptr_bin[ADDR_WIDTH-1:0]`.
- `rptr_gray`  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- `rempty`  out  1  FIFO empty as seen from the read domain.
- `rcount`  out  ADDR_WIDTH+1  number of words in the FIFO from the read-domain view, 0..FIFO_DEP.
- `m_data`  out  DATA_WIDTH  output word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer accepts `m_data` this cycle.

## Operation
- **Synchronizer:** two flops, `wq1` then `wq2`, sample `wptr_gray` on every `R_CLK` edge. Only `wq2` is used. It is Gray-decoded to `wq2_bin` by prefix XOR from the MSB.
- **Read pointer:** `rptr_bin` is an `ADDR_WIDTH+1`-bit binary counter.
  - `rptr_gray` is a register loaded with `next_bin ^ (next_bin >> 1)`, so the pointer crossing domains is glitch-free.
- **Empty:** `rempty = (rptr_gray == wq2)`, compared over the full `ADDR_WIDTH+1` bits.
- **Pop:** `pop = !rempty && (!m_valid || m_ready)`. On a pop:
  - `m_data <= r_data`, taken from the current `r_addr`;
  - `m_valid <= 1`;
  - `rptr_bin` increments by 1.
- **Output stage:** if there is no pop and `m_valid && m_ready`, then `m_valid <= 0`. If `m_valid && !m_ready`, `m_data` and `m_valid` hold.
- **Fill count:** `rcount = wq2_bin - rptr_bin`, modulo `2**(ADDR_WIDTH+1)`. Words held in the output stage are not counted.
- **Wrap-around:**
  - `rptr_bin` rolls from `2**(ADDR_WIDTH+1)-1` to 0.
  - `r_addr` rolls every `FIFO_DEP` pops.
  - The MSB difference keeps full and empty distinguishable.
- **Overflow/underflow:** the block never pops while `rempty=1`. Overflow is prevented on the write side.

## Timing
- **Reset (`R_RST` low, asynchronous):**
  - `wq1`, `wq2`, `rptr_bin`, `rptr_gray` = 0;
  - `r_addr` = 0, `rempty` = 1, `rcount` = 0;
  - `m_valid` = 0, `m_data` = 0.
  - Reset mid-stream discards the word held in the output stage.
- **Write-to-visibility latency:**
  - `wptr_gray` changes before edge k and is captured into `wq1` at edge k and `wq2` at edge k+1.
  - `rempty` falls after edge k+1.
  - The first pop occurs at edge k+2, so `m_valid=1` after edge k+2.
- **Throughput:** with `m_ready` held at 1 and data available, one pop and one transfer happen per cycle.
- **Simultaneous events:**
  - Transfer and pop in the same cycle: `m_valid` stays 1 and `m_data` is replaced.
  - A `wptr_gray` change in the same cycle as a pop is seen two edges later and does not affect the current pop.
- **Pointer update:** `rptr_gray` and `r_addr` update on the same edge as the pop. `rempty` and `rcount` reflect the new value in the following cycle.

## Test plan
- **Reset:** assert `R_RST` with `m_ready=1` and `wptr_gray=0101`. While reset is asserted: `rempty=1`, `m_valid=0`, `rcount=0`, `rptr_gray=0000`, `r_addr=0`.
- **Single word:** memory[0]=0xA5. Change `wptr_gray` 0000→0001 before edge k. Required:
  - `rempty` falls after edge k+1;
  - after edge k+2: `m_valid=1`, `m_data=0xA5`, `rptr_gray=0001`, `rempty=1`;
  - `m_valid` falls after edge k+3.
- **Full FIFO with back-pressure:** memory[i]=i, `wptr_gray=1100` (binary 8), `m_ready=0`. Required:
  - `rcount` reaches 8, then becomes 7 after one pop; `m_data=0x00` held;
  - raising `m_ready` streams 0x01..0x07 on consecutive cycles;
  - `rempty=1` with `rptr_gray=1100` at the end.
- **Wrap:** stream 20 words while the pointer advances. Required:
  - `rptr_gray` follows the Gray sequence 0000→0001→…→1000 and wraps to 0000 after binary 15;
  - `r_addr` cycles 0..7 without a gap;
  - data order is preserved.
- **Reset mid-stream:** with 4 words pending and `m_valid=1`, pulse `R_RST`. Required: outputs go immediately to their reset values; `wptr_gray` is then re-synchronized two edges after release.
- **Ready toggling:** alternate `m_ready` 1/0 per cycle over 6 words. Required: no word lost or duplicated, and `m_data` is stable whenever `m_valid=1` and `m_ready=0`.
